// File: rtl/dmem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_pkg
// Shared types and helpers for the data-memory port arbiter.
//   arb_state_t          : arbiter FSM state (ARB_IDLE / ARB_ACCESS / ARB_RDATA)
//   arb_owner_t          : which requester owns the current access
//   arb_state_to_string  : printable state name for debug views
//   arb_owner_to_string  : printable owner name for debug views
//   starve_ctr_width     : width of the host wait counter for a given limit
// Optional feature macro used by the arbiter: DMEM_ARB_LOCK_EN
// -----------------------------------------------------------------------------
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RDATA  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } arb_owner_t;

  function automatic string arb_state_to_string(input arb_state_t s);
    case (s)
      ARB_IDLE:   return "ARB_IDLE";
      ARB_ACCESS: return "ARB_ACCESS";
      ARB_RDATA:  return "ARB_RDATA";
      default:    return "ARB_???";
    endcase
  endfunction

  function automatic string arb_owner_to_string(input arb_owner_t o);
    case (o)
      OWN_CPU:  return "OWN_CPU";
      OWN_HOST: return "OWN_HOST";
      default:  return "OWN_???";
    endcase
  endfunction

  // Counter must be able to hold the value LIMIT itself.
  function automatic int unsigned starve_ctr_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// dmem_arb_starve_ctr
// Saturating count of consecutive arbitrations the host lost to the CPU.
//   Clk        in  : system clock, rising edge
//   ResetN     in  : asynchronous active-low reset (count -> 0)
//   i_inc      in  : host lost an arbitration (saturates at LIMIT)
//   i_clr      in  : clear (host won, or host not requesting); wins over i_inc
//   o_at_limit out : count == LIMIT, host must win the next contested decision
//   o_count    out : current count, for debug
// -----------------------------------------------------------------------------
module dmem_arb_starve_ctr
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned CW    = starve_ctr_width(LIMIT)
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic          o_at_limit,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] r_count;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIM)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_at_limit = (r_count == LIM);
  assign o_count    = r_count;

endmodule

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares one single-port synchronous data memory between the CPU port and a
// host/debug loader port. CPU has priority; a wait counter forces a host win
// after STARVE_LIMIT consecutive lost contested decisions.
//
// Ports:
//   Clk, ResetN                 : clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata       : CPU request + payload (held until cpu_gnt)
//   host_req/we/addr/wdata      : host request + payload (held until host_gnt)
//   host_lock                   : (DMEM_ARB_LOCK_EN only) lock the memory to host
//   cpu_gnt, host_gnt           : combinational accept; handshake = req&gnt @edge
//   cpu_rvalid/rdata            : CPU read strobe + data (rdata 0 when !rvalid)
//   host_rvalid/rdata           : host read strobe + data (rdata 0 when !rvalid)
//   mem_addr/wr/wdata           : memory side, driven only in ARB_ACCESS
//   mem_rdata                   : memory read data, valid one cycle after addr
//   arb_state                   : current FSM state, for debug
//
// Optional feature macro: DMEM_ARB_LOCK_EN (adds host_lock and the lock flag).
// Timing: handshake edge -> ARB_ACCESS cycle (write commits at its end) ->
//         ARB_RDATA cycle for reads (rvalid). Writes can issue back-to-back.
// -----------------------------------------------------------------------------
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW           = 8,
  parameter int unsigned DW           = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          host_lock,
`endif
  output logic          cpu_gnt,
  output logic          host_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output arb_state_t    arb_state
);

  localparam int unsigned CW = starve_ctr_width(STARVE_LIMIT);

  // ---------------------------------------------------------------------------
  // State and latched transaction payload
  // ---------------------------------------------------------------------------
  arb_state_t    r_state;
  arb_state_t    w_state_next;
  arb_owner_t    r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic          w_decision;
  logic          w_at_limit;
  logic          w_lock;
  logic          w_cpu_gnt;
  logic          w_host_gnt;
  logic          w_ctr_inc;
  logic          w_ctr_clr;
  logic [CW-1:0] w_ctr_count;

`ifdef DMEM_ARB_LOCK_EN
  logic r_lock;

  // Lock is (re)decided on every host handshake from the host_lock value
  // presented with that transaction.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_lock <= 1'b0;
    end else if (w_host_gnt) begin
      r_lock <= host_lock;
    end
  end

  assign w_lock = r_lock;
`else
  assign w_lock = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // A new transaction may be accepted when the memory is free next cycle:
  // idle, returning read data, or finishing a write (which needs no data
  // phase). ResetN is folded in so grants are forced low while reset is held.
  always_comb begin
    w_decision = 1'b0;
    if (ResetN) begin
      case (r_state)
        ARB_IDLE:   w_decision = 1'b1;
        ARB_ACCESS: w_decision = r_we;
        ARB_RDATA:  w_decision = 1'b1;
        default:    w_decision = 1'b0;
      endcase
    end
  end

  // CPU wins contested decisions unless the host has waited long enough or
  // holds the lock. The two grant terms are mutually exclusive by construction.
  always_comb begin
    w_cpu_gnt  = w_decision & cpu_req & ~w_lock & ~(host_req & w_at_limit);
    w_host_gnt = w_decision & host_req & (~cpu_req | w_at_limit | w_lock);
  end

  // Wait counter only moves at decision points and freezes while locked.
  always_comb begin
    w_ctr_inc = w_decision & ~w_lock & host_req & w_cpu_gnt;
    w_ctr_clr = w_decision & ~w_lock & (w_host_gnt | ~host_req);
  end

  dmem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .CW    (CW)
  ) u_starve_ctr (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .i_inc      (w_ctr_inc),
    .i_clr      (w_ctr_clr),
    .o_at_limit (w_at_limit),
    .o_count    (w_ctr_count)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (w_cpu_gnt || w_host_gnt) begin
      w_state_next = ARB_ACCESS;
    end else if (w_decision) begin
      w_state_next = ARB_IDLE;
    end else begin
      case (r_state)
        ARB_ACCESS: w_state_next = ARB_RDATA;   // read: data phase follows
        default:    w_state_next = ARB_IDLE;    // unreachable encodings recover
      endcase
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Payload is captured only on the handshake edge; later changes on the
  // request inputs are ignored for the rest of the transaction.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_owner <= OWN_CPU;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_host_gnt) begin
      r_owner <= OWN_HOST;
      r_we    <= host_we;
      r_addr  <= host_addr;
      r_wdata <= host_wdata;
    end else if (w_cpu_gnt) begin
      r_owner <= OWN_CPU;
      r_we    <= cpu_we;
      r_addr  <= cpu_addr;
      r_wdata <= cpu_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_addr    = '0;
    mem_wr      = 1'b0;
    mem_wdata   = '0;
    cpu_rvalid  = 1'b0;
    host_rvalid = 1'b0;
    cpu_rdata   = '0;
    host_rdata  = '0;
    if (r_state == ARB_ACCESS) begin
      mem_addr  = r_addr;
      mem_wr    = r_we;
      mem_wdata = r_wdata;
    end
    if (r_state == ARB_RDATA) begin
      if (r_owner == OWN_HOST) begin
        host_rvalid = 1'b1;
        host_rdata  = mem_rdata;
      end else begin
        cpu_rvalid  = 1'b1;
        cpu_rdata   = mem_rdata;
      end
    end
  end

  assign cpu_gnt   = w_cpu_gnt;
  assign host_gnt  = w_host_gnt;
  assign arb_state = r_state;

  // Counter value is exported by the sub-module for debug probing only.
  logic w_unused;
  assign w_unused = ^w_ctr_count;

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port 256x16 synchronous data memory between two requesters: the processor control unit (CPU port) and a host/debug loader (HOST port).
- Sits between both requesters and the data memory. Arbitrates per transaction and sequences the write or read access.
- Returns read data with a fixed latency.
- CPU has priority; a bounded-wait counter guarantees the host forward progress.

Parameters:
AW, 8, memory address width
DW, 16, memory data width
STARVE_LIMIT, 4, consecutive lost host arbitrations before the host is forced to win (>=1)

Ports:
Clk  in  1  system clock, rising edge
ResetN  in  1  asynchronous active-low reset
cpu_req / host_req  in  1  transaction request (valid); held with payload until gnt
cpu_we / host_we  in  1  1=write, 0=read
cpu_addr / host_addr  in  AW  memory address
cpu_wdata / host_wdata  in  DW  write data
cpu_gnt / host_gnt  out  1  accept; handshake occurs on a rising edge where req&gnt=1
cpu_rvalid / host_rvalid  out  1  one-cycle read-data strobe
cpu_rdata / host_rdata  out  DW  mem_rdata when own rvalid=1, else 0
mem_addr  out  AW  memory address
mem_wr  out  1  memory write enable
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid the cycle after the address is presented
arb_state  out  arb_state_t  current state, exported for debug viewing

Behaviour:
- Reset (async, ResetN=0):
  - state=ARB_IDLE; wait counter=0; latched payload=0.
  - All outputs 0, gnts forced 0 regardless of req.
  - An in-flight read is discarded and produces no rvalid.
- States:
  - ARB_IDLE: no access in progress.
  - ARB_ACCESS: memory driven from the latched payload.
  - ARB_RDATA: read data returned.
- Decision points: ARB_IDLE, ARB_ACCESS with latched we=1, and ARB_RDATA. gnt is combinational and nonzero only at decision points. ARB_ACCESS with a read gives both gnt=0.
- Winner at a decision point:
  - Only one req: that requester.
  - Both req: CPU, unless the wait counter == STARVE_LIMIT, in which case HOST.
  - At most one gnt is high per cycle.
- On a handshake edge: latch owner, we, addr and wdata; next state=ARB_ACCESS. A decision point with no req goes to ARB_IDLE.
- ARB_ACCESS:
  - mem_addr = latched addr; mem_wdata = latched wdata; mem_wr = latched we.
  - Write: a new decision is allowed in the same cycle, giving back-to-back writes at 1 per cycle.
  - Read: next state=ARB_RDATA.
- ARB_RDATA: owner's rvalid=1 and rdata=mem_rdata. mem_addr, mem_wr and mem_wdata are 0 outside ARB_ACCESS.
- Latency:
  - Write commits at the edge ending the ARB_ACCESS cycle, i.e. the first edge after the handshake.
  - rvalid is high in the second cycle after the handshake cycle. Read throughput is 1 per 2 cycles.
- Wait counter, updated at a decision point:
  - +1 (saturating at STARVE_LIMIT) when host_req=1 and CPU wins.
  - Cleared on a HOST handshake or when host_req=0.
  - Width is $clog2(STARVE_LIMIT+1).
- Requester rules:
  - Payload is sampled only on its handshake edge.
  - req may deassert before gnt (withdrawal is legal, no side effect).
  - Payload changes after the handshake have no effect.
- Same address requested by both ports: serialized in grant order, no merging. A read after a write to the same address returns the new data.

Optional Feature:
- DMEM_ARB_LOCK_EN defined:
  - Adds input host_lock (1 bit).
  - A HOST handshake with host_lock=1 sets a lock flag. While it is set, cpu_gnt=0 at every decision point and the wait counter is held.
  - A HOST handshake with host_lock=0, or reset, clears the flag.
  - Intended for program loading while the CPU is halted.
- Undefined: no host_lock port, no lock flag; behaviour exactly as above.

Decomposition:
- The shared processor package holds:
  - typedef enum arb_state_t {ARB_IDLE, ARB_ACCESS, ARB_RDATA}.
  - typedef enum arb_owner_t {OWN_CPU, OWN_HOST}.
  - Helper arb_state_to_string, alongside the existing state-name helpers.
- One natural sub-module: dmem_arb_starve_ctr (saturating wait counter, inputs inc/clr, output at_limit). Everything else stays in a single module.

Test Plan:
- Reset: ResetN=0 with cpu_req=host_req=1 -> cpu_gnt=host_gnt=0, mem_wr=0, arb_state=ARB_IDLE. Release -> cpu_gnt=1 in the first decision cycle.
- CPU write then read:
  - Write addr 0x10, data 0x1234: cpu_gnt in the request cycle; next cycle mem_wr=1, mem_addr=0x10, mem_wdata=0x1234.
  - Read 0x10: cpu_rvalid=1 with cpu_rdata=0x1234 two cycles after the handshake; host_rvalid stays 0.
- Starvation: both ports issue continuous writes, STARVE_LIMIT=4 -> grant sequence CPU,CPU,CPU,CPU,HOST repeating; never two gnts in one cycle.
- Back-to-back: 3 CPU writes (0x01..0x03) -> mem_wr high 3 consecutive cycles. A following read gives both gnt=0 during its ARB_ACCESS cycle.
- Reset mid-read: ResetN=0 during ARB_ACCESS of a host read of 0x20 -> no host_rvalid, arb_state=ARB_IDLE, all outputs 0.
- Lock (DMEM_ARB_LOCK_EN):
  - Host writes 0x00..0x03 with host_lock=1 while cpu_req=1 -> cpu_gnt stays 0.
  - Host write with host_lock=0 -> cpu_gnt=1 at the next decision point.
